// File: rtl/nbit_skid_buffer_pkg.sv
// -----------------------------------------------------------------------------
// nbit_skid_buffer_pkg
// Shared constants for the two-entry skid buffer:
//   - FSM state encoding (EMPTY / BUSY / FULL)
//   - default data width
// -----------------------------------------------------------------------------
package nbit_skid_buffer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // BUSY  = head word valid, skid empty
    // FULL  = head and skid valid, upstream stalled
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/nbit_reg_en.sv
// -----------------------------------------------------------------------------
// nbit_reg_en
// DATA_WIDTH-bit register with load enable; holds its value when load=0.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, clears q to 0
//   load  - capture d on the next rising edge
//   d     - data in
//   q     - registered data out
// -----------------------------------------------------------------------------
module nbit_reg_en
    import nbit_skid_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/nbit_skid_buffer.sv
// -----------------------------------------------------------------------------
// nbit_skid_buffer
// Two-entry valid/ready register slice. The head (main) register drives
// out_data; the skid register catches the one word that arrives in the cycle
// the consumer stalls, so in_ready can come straight from a flop.
// Ports:
//   clk, reset           - rising-edge clock, async active-high reset
//   flush                - synchronous discard of all stored words
//   in_valid/in_ready    - upstream handshake, in_data is the offered word
//   out_valid/out_ready  - downstream handshake, out_data is the head word
//   level                - stored word count, 0..2
// -----------------------------------------------------------------------------
module nbit_skid_buffer
    import nbit_skid_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            level
);

    logic [1:0]            state;
    logic [1:0]            next_state;
    // Occupancy flags are registered copies of the next-state decode so that
    // in_ready / out_valid / level are pure flop outputs.
    logic                  main_full;
    logic                  skid_full;

    logic                  in_xfer;
    logic                  out_xfer;
    logic                  main_load;
    logic                  skid_load;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            main_full <= 1'b0;
            skid_full <= 1'b0;
        end else begin
            state     <= next_state;
            main_full <= (next_state == ST_BUSY) || (next_state == ST_FULL);
            skid_full <= (next_state == ST_FULL);
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: if (in_xfer) next_state = ST_BUSY;
            ST_BUSY: begin
                if (in_xfer && !out_xfer)      next_state = ST_FULL;
                else if (!in_xfer && out_xfer) next_state = ST_EMPTY;
            end
            ST_FULL:  if (out_xfer) next_state = ST_BUSY;
            default:  next_state = ST_EMPTY;  // illegal encoding recovers
        endcase
        if (flush) next_state = ST_EMPTY;
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        in_ready  = ~skid_full;
        out_valid = main_full;
        level     = {1'b0, main_full} + {1'b0, skid_full};
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_data;
        case (state)
            ST_EMPTY: main_load = in_xfer;
            ST_BUSY: begin
                // Pass-through when both sides move; otherwise park the
                // new word in the skid so the head stays put.
                main_load = in_xfer && out_xfer;
                skid_load = in_xfer && !out_xfer;
            end
            ST_FULL: begin
                main_load = out_xfer;
                main_d    = skid_q;
            end
            default: ;
        endcase
        // Stored words are discarded on flush; no point loading either entry.
        if (flush) begin
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    assign out_data = main_q;

    nbit_reg_en #(.DATA_WIDTH(DATA_WIDTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    nbit_reg_en #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );

    // Upstream must hold a stalled word until it is taken (or withdrawn).
    property p_in_hold;
        @(posedge clk) disable iff (reset)
            (in_valid && !in_ready && !flush) |=> (!in_valid || $stable(in_data));
    endproperty
    a_in_hold: assert property (p_in_hold);

endmodule

// File: tb/tb_nbit_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_nbit_skid_buffer
// Scenario tasks for the skid buffer. Words are pushed into a queue when an
// input transfer is observed and popped/compared on each output transfer.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_nbit_skid_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  level;

    logic        w_flush;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [15:0] w_in_data;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [15:0] w_out_data;
    logic [1:0]  w_level;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  sb[$];

    nbit_skid_buffer #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    nbit_skid_buffer #(.DATA_WIDTH(16)) dut_w (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_flush),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_data),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_data  (w_out_data),
        .level     (w_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------ reset
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_data = 16'h0000; w_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (level !== 2'd0)     begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        tick();
        reset = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (level !== 2'd2) begin n_fail++; $display("FAIL prereset_level: got %0d want 2", level); end
        // Asynchronous reset in the middle of a cycle while FULL.
        #2 reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (level !== 2'd0)     begin n_fail++; $display("FAIL midreset_level: got %0d want 0", level); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL midreset_out_data: got %h want 00", out_data); end
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL postreset_idle: cycle %0d out_valid got %b want 0", c, out_valid); end
        end
        tick();
    endtask

    // ------------------------------------------------------------- throughput
    task automatic test_throughput();
        logic [7:0] exp;
        int         got = 0;
        sb.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) begin in_valid = 1'b1; in_data = i[7:0]; end
            else in_valid = 1'b0;
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL thru_in_ready: cycle %0d got %b want 1", i, in_ready); end
            if (i > 1) begin
                n_checks++; if (level !== 2'd1) begin n_fail++; $display("FAIL thru_level: cycle %0d got %0d want 1", i, level); end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL thru_spurious: got %h want no output", out_data); end
                else begin
                    exp = sb.pop_front(); got++;
                    if (out_data !== exp) begin n_fail++; $display("FAIL thru_data: got %h want %h", out_data, exp); end
                end
            end
            tick();
        end
        @(negedge clk);
        n_checks++; if (got != 8)          begin n_fail++; $display("FAIL thru_count: got %0d want 8", got); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL thru_drained: out_valid got %b want 0", out_valid); end
        tick();
    endtask

    // ----------------------------------------------------------- backpressure
    task automatic test_backpressure();
        logic [7:0] words [3];
        logic [7:0] exp;
        int         idx = 0;
        int         got = 0;
        words[0] = 8'hA5; words[1] = 8'h5A; words[2] = 8'hFF;
        sb.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) out_ready = 1'b1;
            if (idx < 3) begin in_valid = 1'b1; in_data = words[idx]; end
            else in_valid = 1'b0;
            @(negedge clk);
            if (c == 0) begin n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL bp_level0: got %0d want 0", level); end end
            if (c == 1) begin n_checks++; if (level !== 2'd1) begin n_fail++; $display("FAIL bp_level1: got %0d want 1", level); end end
            if (c == 2) begin
                n_checks++; if (level !== 2'd2)    begin n_fail++; $display("FAIL bp_level2: got %0d want 2", level); end
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
            end
            if (c == 3) begin
                n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_stall_ready: got %b want 0", in_ready); end
                n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL bp_hold: got %h want a5", out_data); end
            end
            if (in_valid && in_ready) begin sb.push_back(in_data); idx++; end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_spurious: got %h want no output", out_data); end
                else begin
                    exp = sb.pop_front(); got++;
                    if (out_data !== exp) begin n_fail++; $display("FAIL bp_order: got %h want %h", out_data, exp); end
                end
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", got); end
    endtask

    // ---------------------------------------------------------------- random
    task automatic test_random();
        localparam int N = 1000;
        logic [7:0] exp;
        int         sent = 0;
        int         recv = 0;
        bit         pending = 1'b0;
        sb.delete();
        in_valid = 1'b0;
        for (int c = 0; c < 20000 && recv < N; c++) begin
            out_ready = 1'($urandom_range(1, 0));
            if (!pending) begin
                if (sent < N && $urandom_range(1, 0) == 1) begin
                    in_valid = 1'b1; in_data = 8'($urandom); pending = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            n_checks++; if (int'(level) != sb.size()) begin n_fail++; $display("FAIL rnd_level: got %0d want %0d", level, sb.size()); end
            n_checks++; if (in_ready !== (sb.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, sb.size() < 2); end
            n_checks++; if (out_valid !== (sb.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid: got %b want %b", out_valid, sb.size() > 0); end
            if (sb.size() > 0) begin
                n_checks++; if (out_data !== sb[0]) begin n_fail++; $display("FAIL rnd_head: got %h want %h", out_data, sb[0]); end
            end
            if (in_valid && in_ready) begin sb.push_back(in_data); sent++; pending = 1'b0; end
            if (out_valid && out_ready && sb.size() > 0) begin
                exp = sb.pop_front(); recv++;
                n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL rnd_data: got %h want %h", out_data, exp); end
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (recv != N) begin n_fail++; $display("FAIL rnd_timeout: received %0d want %0d", recv, N); end
    endtask

    // ----------------------------------------------------------------- flush
    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h10;
        tick();
        in_data = 8'h20;
        tick();
        in_data = 8'h30; flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (level !== 2'd2) begin n_fail++; $display("FAIL flush_setup_level: got %0d want 2", level); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (level !== 2'd0)     begin n_fail++; $display("FAIL flush_level: got %0d want 0", level); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak: cycle %0d got word %h want none", c, out_data); end
        end
        tick();
        // Flush from BUSY drops a word offered with in_ready=1.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h40;
        tick();
        in_data = 8'h50; flush = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_busy_ready: got %b want 1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL flush_busy_level: got %0d want 0", level); end
        tick();
        // Buffer works normally after a flush.
        in_valid = 1'b1; in_data = 8'h66; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL flush_after_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 8'h66)  begin n_fail++; $display("FAIL flush_after_data: got %h want 66", out_data); end
        tick();
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------- wide build
    task automatic test_wide();
        logic [1:0] exp_level [5];
        int         beef_seen = 0;
        exp_level[0] = 2'd0; exp_level[1] = 2'd1; exp_level[2] = 2'd2;
        exp_level[3] = 2'd1; exp_level[4] = 2'd0;
        for (int c = 0; c < 5; c++) begin
            w_in_valid  = (c < 2);
            w_in_data   = (c == 0) ? 16'hBEEF : 16'h1234;
            w_out_ready = (c >= 2);
            @(negedge clk);
            n_checks++; if (w_level !== exp_level[c]) begin n_fail++; $display("FAIL wide_level: cycle %0d got %0d want %0d", c, w_level, exp_level[c]); end
            if (c == 2) begin
                n_checks++; if (w_out_data !== 16'hBEEF) begin n_fail++; $display("FAIL wide_head: got %h want beef", w_out_data); end
            end
            if (c == 3) begin
                n_checks++; if (w_out_data !== 16'h1234) begin n_fail++; $display("FAIL wide_second: got %h want 1234", w_out_data); end
            end
            if (w_out_valid && w_out_ready && w_out_data == 16'hBEEF) beef_seen++;
            tick();
        end
        w_in_valid = 1'b0; w_out_ready = 1'b0;
        n_checks++; if (beef_seen != 1) begin n_fail++; $display("FAIL wide_once: got %0d want 1", beef_seen); end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_backpressure();
        test_random();
        test_flush();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
